// File: rtl/cluster_l2_rr_arb.sv
// cluster_l2_rr_arb: N-channel cluster-to-L2 request arbiter and response router.
// Requests: round-robin arbitration into a one-entry registered output stage;
// the winning channel index is prepended to the channel source on the way to L2.
// Responses: routed combinationally back by the top source bits; out-of-range
// indices are dropped and flagged on the sticky rsp_err_o.
// Optional macro CLUSTER_L2_ARB_PERF_EN enables saturating per-channel grant counters.
module cluster_l2_rr_arb #(
    parameter int  NUM_CH       = 4,
    parameter int  REQ_W        = 128,
    parameter int  RSP_W        = 128,
    parameter int  CH_SRC_BITS  = 8,
    localparam int IDX_W        = (NUM_CH == 1) ? 0 : $clog2(NUM_CH),
    localparam int OUT_SRC_BITS = CH_SRC_BITS + IDX_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             req_in_valid_i,
    output logic [NUM_CH-1:0]             req_in_ready_o,
    input  logic [NUM_CH*REQ_W-1:0]       req_in_payload_i,
    input  logic [NUM_CH*CH_SRC_BITS-1:0] req_in_source_i,
    output logic                          req_out_valid_o,
    input  logic                          req_out_ready_i,
    output logic [REQ_W-1:0]              req_out_payload_o,
    output logic [OUT_SRC_BITS-1:0]       req_out_source_o,
    input  logic                          rsp_in_valid_i,
    output logic                          rsp_in_ready_o,
    input  logic [RSP_W-1:0]              rsp_in_payload_i,
    input  logic [OUT_SRC_BITS-1:0]       rsp_in_source_i,
    output logic [NUM_CH-1:0]             rsp_out_valid_o,
    input  logic [NUM_CH-1:0]             rsp_out_ready_i,
    output logic [NUM_CH*RSP_W-1:0]       rsp_out_payload_o,
    output logic [NUM_CH*CH_SRC_BITS-1:0] rsp_out_source_o,
    output logic                          rsp_err_o,
    output logic [NUM_CH*16-1:0]          perf_grant_cnt_o
);

    // Index registers keep at least one bit so NUM_CH==1 elaborates cleanly.
    localparam int          IDX_WS = (IDX_W == 0) ? 1 : IDX_W;
    localparam int unsigned NCH    = NUM_CH;

    logic [IDX_WS-1:0]       ptr_q, ptr_d;
    logic                    valid_q, valid_d;
    logic [REQ_W-1:0]        payload_q, payload_d;
    logic [OUT_SRC_BITS-1:0] source_q, source_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    load_en;
    logic                    any_grant;
    logic [NUM_CH-1:0]       grant;
    logic [IDX_WS-1:0]       win_idx;
    logic [IDX_WS-1:0]       nxt_ptr;
    logic [REQ_W-1:0]        win_payload;
    logic [CH_SRC_BITS-1:0]  win_src;
    logic [OUT_SRC_BITS-1:0] win_src_full;

    logic [IDX_WS-1:0]       rsp_idx;
    logic                    rsp_in_range;

    assign load_en = ~valid_q | req_out_ready_i;

    // Round-robin search: first valid channel at or after the pointer, wrapping.
    always_comb begin
        grant       = '0;
        any_grant   = 1'b0;
        win_idx     = '0;
        nxt_ptr     = '0;
        win_payload = '0;
        win_src     = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            for (int unsigned j = 0; j < NCH; j++) begin
                if (!any_grant && (j == (32'(ptr_q) + k) % NCH) && req_in_valid_i[j]) begin
                    any_grant   = 1'b1;
                    grant[j]    = 1'b1;
                    win_idx     = IDX_WS'(j);
                    nxt_ptr     = IDX_WS'((j + 1) % NCH);
                    win_payload = req_in_payload_i[REQ_W*j +: REQ_W];
                    win_src     = req_in_source_i[CH_SRC_BITS*j +: CH_SRC_BITS];
                end
            end
        end
    end

    generate
        if (IDX_W > 0) begin : g_prefix
            assign win_src_full = {win_idx[IDX_W-1:0], win_src};
        end else begin : g_noprefix
            assign win_src_full = win_src;
        end
    endgenerate

    assign req_in_ready_o = grant & {NUM_CH{load_en}};

    // Output stage next state: load the winner, drain when empty-handed, else hold.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        source_d  = source_q;
        ptr_d     = ptr_q;
        if (load_en) begin
            if (any_grant) begin
                valid_d   = 1'b1;
                payload_d = win_payload;
                source_d  = win_src_full;
                ptr_d     = nxt_ptr;
            end else if (req_out_ready_i) begin
                valid_d = 1'b0;
            end
        end
    end

    // Request output register, pointer and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            source_q  <= '0;
            ptr_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            source_q  <= source_d;
            ptr_q     <= ptr_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign req_out_valid_o   = valid_q;
    assign req_out_payload_o = payload_q;
    assign req_out_source_o  = source_q;

    generate
        if (IDX_W > 0) begin : g_rsp_idx
            assign rsp_idx = rsp_in_source_i[OUT_SRC_BITS-1 -: IDX_W];
        end else begin : g_rsp_idx0
            assign rsp_idx = '0;
        end
    endgenerate

    // Response routing; an index with no matching channel is accepted and dropped.
    always_comb begin
        rsp_out_valid_o = '0;
        rsp_in_ready_o  = 1'b1;
        rsp_in_range    = 1'b0;
        for (int unsigned j = 0; j < NCH; j++) begin
            if (rsp_idx == IDX_WS'(j)) begin
                rsp_in_range       = 1'b1;
                rsp_out_valid_o[j] = rsp_in_valid_i;
                rsp_in_ready_o     = rsp_out_ready_i[j];
            end
        end
        rsp_err_d = rsp_err_q | (rsp_in_valid_i & ~rsp_in_range);
    end

    assign rsp_out_payload_o = {NUM_CH{rsp_in_payload_i}};
    assign rsp_out_source_o  = {NUM_CH{rsp_in_source_i[CH_SRC_BITS-1:0]}};
    assign rsp_err_o         = rsp_err_q;

`ifdef CLUSTER_L2_ARB_PERF_EN
    logic [NUM_CH-1:0][15:0] perf_q, perf_d;

    // Saturating per-channel count of accepted requests.
    always_comb begin
        perf_d = perf_q;
        for (int unsigned j = 0; j < NCH; j++) begin
            if (req_in_valid_i[j] && req_in_ready_o[j] && (perf_q[j] != 16'hFFFF)) begin
                perf_d[j] = perf_q[j] + 16'd1;
            end
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_grant_cnt_o = perf_q;
`else
    assign perf_grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cluster_l2_rr_arb.sv
// tb_cluster_l2_rr_arb: directed scoreboard bench for cluster_l2_rr_arb.
// Main instance NUM_CH=4; a second NUM_CH=3 instance covers out-of-range responses.
module tb_cluster_l2_rr_arb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // NUM_CH = 4 instance
    logic [3:0]   req_in_valid_i, req_in_ready_o;
    logic [511:0] req_in_payload_i;
    logic [31:0]  req_in_source_i;
    logic         req_out_valid_o, req_out_ready_i;
    logic [127:0] req_out_payload_o;
    logic [9:0]   req_out_source_o;
    logic         rsp_in_valid_i, rsp_in_ready_o;
    logic [127:0] rsp_in_payload_i;
    logic [9:0]   rsp_in_source_i;
    logic [3:0]   rsp_out_valid_o, rsp_out_ready_i;
    logic [511:0] rsp_out_payload_o;
    logic [31:0]  rsp_out_source_o;
    logic         rsp_err_o;
    logic [63:0]  perf_grant_cnt_o;

    // NUM_CH = 3 instance
    logic [2:0]   req_in_valid3, req_in_ready3;
    logic [383:0] req_in_payload3;
    logic [23:0]  req_in_source3;
    logic         req_out_valid3, req_out_ready3;
    logic [127:0] req_out_payload3;
    logic [9:0]   req_out_source3;
    logic         rsp_in_valid3, rsp_in_ready3;
    logic [127:0] rsp_in_payload3;
    logic [9:0]   rsp_in_source3;
    logic [2:0]   rsp_out_valid3, rsp_out_ready3;
    logic [383:0] rsp_out_payload3;
    logic [23:0]  rsp_out_source3;
    logic         rsp_err3;
    logic [47:0]  perf_grant_cnt3;

    cluster_l2_rr_arb #(.NUM_CH(4), .REQ_W(128), .RSP_W(128), .CH_SRC_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_in_valid_i(req_in_valid_i), .req_in_ready_o(req_in_ready_o),
        .req_in_payload_i(req_in_payload_i), .req_in_source_i(req_in_source_i),
        .req_out_valid_o(req_out_valid_o), .req_out_ready_i(req_out_ready_i),
        .req_out_payload_o(req_out_payload_o), .req_out_source_o(req_out_source_o),
        .rsp_in_valid_i(rsp_in_valid_i), .rsp_in_ready_o(rsp_in_ready_o),
        .rsp_in_payload_i(rsp_in_payload_i), .rsp_in_source_i(rsp_in_source_i),
        .rsp_out_valid_o(rsp_out_valid_o), .rsp_out_ready_i(rsp_out_ready_i),
        .rsp_out_payload_o(rsp_out_payload_o), .rsp_out_source_o(rsp_out_source_o),
        .rsp_err_o(rsp_err_o), .perf_grant_cnt_o(perf_grant_cnt_o)
    );

    cluster_l2_rr_arb #(.NUM_CH(3), .REQ_W(128), .RSP_W(128), .CH_SRC_BITS(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_in_valid_i(req_in_valid3), .req_in_ready_o(req_in_ready3),
        .req_in_payload_i(req_in_payload3), .req_in_source_i(req_in_source3),
        .req_out_valid_o(req_out_valid3), .req_out_ready_i(req_out_ready3),
        .req_out_payload_o(req_out_payload3), .req_out_source_o(req_out_source3),
        .rsp_in_valid_i(rsp_in_valid3), .rsp_in_ready_o(rsp_in_ready3),
        .rsp_in_payload_i(rsp_in_payload3), .rsp_in_source_i(rsp_in_source3),
        .rsp_out_valid_o(rsp_out_valid3), .rsp_out_ready_i(rsp_out_ready3),
        .rsp_out_payload_o(rsp_out_payload3), .rsp_out_source_o(rsp_out_source3),
        .rsp_err_o(rsp_err3), .perf_grant_cnt_o(perf_grant_cnt3)
    );

    typedef struct packed {
        logic [9:0]   src;
        logic [127:0] pl;
    } req_exp_t;

    typedef struct packed {
        logic [3:0]   vld;
        logic [31:0]  src;
        logic [127:0] pl;
    } rsp_exp_t;

    req_exp_t req_q[$];
    rsp_exp_t rsp_q[$];
    int       checks = 0;
    int       errors = 0;
    logic     mon_en = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pl(input int ch, input int tag);
        return {tag[7:0], ch[7:0], 112'h0123456789ABCDEFFEDCBA987654};
    endfunction

    task automatic set_req(input logic [3:0] v, input logic [31:0] srcs, input int tag);
        req_in_valid_i  = v;
        req_in_source_i = srcs;
        for (int c = 0; c < 4; c++) req_in_payload_i[128*c +: 128] = pl(c, tag);
    endtask

    task automatic push_req(input logic [9:0] src, input logic [127:0] p);
        req_exp_t e;
        e.src = src;
        e.pl  = p;
        req_q.push_back(e);
    endtask

    // Monitor: pops an expectation for every output handshake of the 4-channel instance.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (req_out_valid_o && req_out_ready_i) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", {118'd0, req_out_source_o}, 128'd0);
                end else begin
                    req_exp_t e;
                    e = req_q.pop_front();
                    chk("req_src", {118'd0, req_out_source_o}, {118'd0, e.src});
                    chk("req_payload", req_out_payload_o, e.pl);
                end
            end
            if (rsp_in_valid_i && rsp_in_ready_o) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", {118'd0, rsp_in_source_i}, 128'd0);
                end else begin
                    rsp_exp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_valid", {124'd0, rsp_out_valid_o}, {124'd0, r.vld});
                    chk("rsp_src", {96'd0, rsp_out_source_o}, {96'd0, r.src});
                    for (int c = 0; c < 4; c++)
                        chk("rsp_payload", rsp_out_payload_o[128*c +: 128], r.pl);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] srcs;

    initial begin
        rst_n = 1'b0;
        req_in_valid_i = '0; req_in_payload_i = '0; req_in_source_i = '0; req_out_ready_i = 1'b0;
        rsp_in_valid_i = 1'b0; rsp_in_payload_i = '0; rsp_in_source_i = '0; rsp_out_ready_i = '0;
        req_in_valid3 = '0; req_in_payload3 = '0; req_in_source3 = '0; req_out_ready3 = 1'b0;
        rsp_in_valid3 = 1'b0; rsp_in_payload3 = '0; rsp_in_source3 = '0; rsp_out_ready3 = '0;
        srcs = {8'h13, 8'h12, 8'h11, 8'h10};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {127'd0, req_out_valid_o}, 128'd0);
        chk("rst_src", {118'd0, req_out_source_o}, 128'd0);
        chk("rst_payload", req_out_payload_o, 128'd0);
        chk("rst_err", {126'd0, rsp_err_o, rsp_err3}, 128'd0);
        chk("rst_perf", {64'd0, perf_grant_cnt_o}, 128'd0);
        chk("rst_in_ready", {124'd0, req_in_ready_o}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All four channels contending: grants rotate 0,1,2,3,0,1,2,3.
        set_req(4'hF, srcs, 1);
        req_out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) push_req({2'(i % 4), 8'(8'h10 + i % 4)}, pl(i % 4, 1));
        @(negedge clk);
        chk("rr_ready_p0", {124'd0, req_in_ready_o}, {124'd0, 4'b0001});
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr_ready_p1", {124'd0, req_in_ready_o}, {124'd0, 4'b0010});
        repeat (7) @(posedge clk);
        #1 set_req(4'h0, srcs, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr_drained", {127'd0, req_out_valid_o}, 128'd0);

        // Stall with ch1/ch3 pending: ch1 held, then ch3 wins after the pointer.
        @(posedge clk); #1;
        set_req(4'b1010, srcs, 3);
        req_out_ready_i = 1'b0;
        push_req(10'h111, pl(1, 3));
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", {124'd0, req_in_ready_o}, 128'd0);
            chk("stall_valid", {127'd0, req_out_valid_o}, 128'd1);
            chk("stall_src", {118'd0, req_out_source_o}, {118'd0, 10'h111});
            chk("stall_payload", req_out_payload_o, pl(1, 3));
        end
        @(posedge clk); #1;
        req_out_ready_i = 1'b1;
        push_req(10'h313, pl(3, 3));
        @(negedge clk);
        chk("stall_next_grant", {124'd0, req_in_ready_o}, {124'd0, 4'b1000});
        @(posedge clk); #1;
        set_req(4'h0, srcs, 3);
        @(posedge clk); #1;

        // Single request from ch2, source 5A: one-cycle latency, prefixed source.
        set_req(4'b0100, {8'h13, 8'h5A, 8'h11, 8'h10}, 2);
        push_req(10'h25A, pl(2, 2));
        @(posedge clk); #1;
        set_req(4'h0, srcs, 2);
        @(negedge clk);
        chk("lat_valid", {127'd0, req_out_valid_o}, 128'd1);
        chk("lat_src", {118'd0, req_out_source_o}, {118'd0, 10'h25A});
        @(posedge clk); #1;
`ifndef CLUSTER_L2_ARB_PERF_EN
        chk("perf_tied_zero", {64'd0, perf_grant_cnt_o}, 128'd0);
`endif

        // Response to ch3 with ch3 not ready, then ready.
        rsp_in_valid_i   = 1'b1;
        rsp_in_source_i  = 10'h3C4;
        rsp_in_payload_i = 128'hDEADBEEF_00112233_44556677_8899AABB;
        rsp_out_ready_i  = 4'b0111;
        @(negedge clk);
        chk("rsp_route_vld", {124'd0, rsp_out_valid_o}, {124'd0, 4'b1000});
        chk("rsp_route_rdy", {127'd0, rsp_in_ready_o}, 128'd0);
        @(posedge clk); #1;
        rsp_out_ready_i = 4'b1111;
        rsp_q.push_back({4'b1000, 32'hC4C4C4C4, 128'hDEADBEEF_00112233_44556677_8899AABB});
        @(negedge clk);
        chk("rsp_hs_rdy", {127'd0, rsp_in_ready_o}, 128'd1);
        @(posedge clk); #1;
        rsp_in_source_i = 10'h0A7;
        rsp_out_ready_i = 4'b0001;
        rsp_q.push_back({4'b0001, 32'hA7A7A7A7, 128'hDEADBEEF_00112233_44556677_8899AABB});
        @(posedge clk); #1;
        rsp_in_valid_i = 1'b0;
        @(negedge clk);
        chk("rsp_err_pow2", {127'd0, rsp_err_o}, 128'd0);

        // NUM_CH=3: index 2 routes normally, index 3 is dropped and flagged.
        rsp_in_valid3  = 1'b1;
        rsp_in_source3 = 10'h2AB;
        rsp_out_ready3 = 3'b011;
        @(negedge clk);
        chk("n3_vld_in_range", {125'd0, rsp_out_valid3}, {125'd0, 3'b100});
        chk("n3_rdy_in_range", {127'd0, rsp_in_ready3}, 128'd0);
        @(posedge clk); #1;
        rsp_in_source3 = 10'h3AB;
        @(negedge clk);
        chk("n3_err_before", {127'd0, rsp_err3}, 128'd0);
        chk("n3_vld_oor", {125'd0, rsp_out_valid3}, 128'd0);
        chk("n3_rdy_oor", {127'd0, rsp_in_ready3}, 128'd1);
        @(posedge clk); #1;
        rsp_in_valid3 = 1'b0;
        @(negedge clk);
        chk("n3_err_set", {127'd0, rsp_err3}, 128'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("n3_err_sticky", {127'd0, rsp_err3}, 128'd1);

        // Reset while a request is held discards it and clears the error flag.
        @(posedge clk); #1;
        set_req(4'b0001, srcs, 5);
        req_out_ready_i = 1'b0;
        @(posedge clk); #1;
        set_req(4'h0, srcs, 5);
        @(negedge clk);
        chk("held_valid", {127'd0, req_out_valid_o}, 128'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_valid", {127'd0, req_out_valid_o}, 128'd0);
        chk("midrst_src", {118'd0, req_out_source_o}, 128'd0);
        chk("midrst_err", {127'd0, rsp_err3}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_out_ready_i = 1'b1;

`ifdef CLUSTER_L2_ARB_PERF_EN
        // Sustained ch0 traffic saturates its counter; reset mid-stream clears it.
        mon_en = 1'b0;
        set_req(4'b0001, srcs, 6);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("perf_cnt10", {112'd0, perf_grant_cnt_o[15:0]}, 128'd10);
        chk("perf_others", {80'd0, perf_grant_cnt_o[63:16]}, 128'd0);
        repeat (65600 - 10) @(posedge clk);
        @(negedge clk);
        chk("perf_sat", {112'd0, perf_grant_cnt_o[15:0]}, {112'd0, 16'hFFFF});
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("perf_rst_cnt", {64'd0, perf_grant_cnt_o}, 128'd0);
        chk("perf_rst_valid", {127'd0, req_out_valid_o}, 128'd0);
        @(posedge clk); #1;
        set_req(4'h0, srcs, 6);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("req_queue_empty", 128'(req_q.size()), 128'd0);
        chk("rsp_queue_empty", 128'(rsp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
